neuron_layer_train_seq: RTL and testbench



---
 rtl/neuron_layer_train_seq_pkg.sv | 13 +
 rtl/neuron_layer_train_seq_if.sv | 48 ++++
 rtl/neuron_layer_train_seq_abs_err_sum.sv | 23 ++
 rtl/neuron_layer_train_seq.sv | 144 ++++++++++++++
 tb/tb_neuron_layer_train_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_layer_train_seq_pkg.sv
// Shared types for the neuron layer training sequencer: value types, FSM state encoding, helpers.
package neuron_layer_train_seq_pkg;

  typedef logic [7:0]         zero2one_t;
  typedef logic signed [15:0] frac_t;

  typedef enum logic [2:0] {IDLE, FIRE, WAIT, LEARN, RESULT} train_seq_state_t;

  function automatic zero2one_t abs_diff(input zero2one_t a, input zero2one_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/neuron_layer_train_seq_if.sv
// Sample, layer and result signals of the sequencer; slave = sequencer view, master = surrounding logic.
interface neuron_layer_train_seq_if #(
  parameter int N     = 16,
  parameter int M     = 56,
  parameter int CNT_W = 16
) ();
  import neuron_layer_train_seq_pkg::*;

  localparam int ERR_W = $bits(zero2one_t) + $clog2(M + 1);

  logic                  s_valid;
  logic                  s_ready;
  zero2one_t [N-1:0]     s_in;
  zero2one_t [M-1:0]     s_expected;
  logic                  s_learn;
  logic                  layer_valid;
  logic                  layer_learn;
  zero2one_t [N-1:0]     layer_in;
  zero2one_t [M-1:0]     layer_expected_out;
  zero2one_t [M-1:0]     layer_out;
  logic                  r_valid;
  logic                  r_ready;
  zero2one_t [M-1:0]     r_out;
  logic [CNT_W-1:0]      r_idx;
  logic                  busy;
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
  logic [ERR_W-1:0]      r_err;
`endif

  modport slave (
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
    output r_err,
`endif
    input  s_valid, s_in, s_expected, s_learn, layer_out, r_ready,
    output s_ready, layer_valid, layer_learn, layer_in, layer_expected_out,
    output r_valid, r_out, r_idx, busy
  );

  modport master (
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
    input  r_err,
`endif
    output s_valid, s_in, s_expected, s_learn, layer_out, r_ready,
    input  s_ready, layer_valid, layer_learn, layer_in, layer_expected_out,
    input  r_valid, r_out, r_idx, busy
  );

endinterface

// File: rtl/neuron_layer_train_seq_abs_err_sum.sv
// abs_err_sum: combinational sum of |a[i]-b[i]| over M lanes; only built with NEURON_LAYER_TRAIN_SEQ_ERR_EN.
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
module abs_err_sum
  import neuron_layer_train_seq_pkg::*;
#(
  parameter int M     = 56,
  parameter int OUT_W = $bits(zero2one_t) + $clog2(M + 1)
) (
  input  zero2one_t [M-1:0] a_i,
  input  zero2one_t [M-1:0] b_i,
  output logic [OUT_W-1:0]  sum_o
);

  // Written as a chain; synthesis is free to rebalance it into a tree.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < M; i++) begin
      sum_o = sum_o + OUT_W'(abs_diff(a_i[i], b_i[i]));
    end
  end

endmodule
`endif

// File: rtl/neuron_layer_train_seq.sv
// Sequencer for one neuron_learn layer: accept -> fire -> wait INFER_LAT -> (learn) -> result; r_valid 2+INFER_LAT(+LEARN_CYCLES) cycles after accept.
// One sample in flight: s_ready only in IDLE, result held until r_ready. NEURON_LAYER_TRAIN_SEQ_ERR_EN adds r_err.
module neuron_layer_train_seq
  import neuron_layer_train_seq_pkg::*;
#(
  parameter int N            = 16,
  parameter int M            = 56,
  parameter int INFER_LAT    = 1,
  parameter int LEARN_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  neuron_layer_train_seq_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_FIRE   = FIRE;
  localparam logic [2:0] ST_WAIT   = WAIT;
  localparam logic [2:0] ST_LEARN  = LEARN;
  localparam logic [2:0] ST_RESULT = RESULT;

  localparam int LAT_MAX = (INFER_LAT > LEARN_CYCLES) ? INFER_LAT : LEARN_CYCLES;
  localparam int WC_W    = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int ERR_W   = $bits(zero2one_t) + $clog2(M + 1);

  logic [2:0]        state_q, state_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  zero2one_t [N-1:0] in_q, in_d;
  zero2one_t [M-1:0] exp_q, exp_d;
  logic              learn_q, learn_d;
  zero2one_t [M-1:0] out_q, out_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
  logic [ERR_W-1:0]  err_q, err_d, err_sum;

  abs_err_sum #(.M(M), .OUT_W(ERR_W)) u_abs_err_sum (
    .a_i   (bus.layer_out),
    .b_i   (exp_q),
    .sum_o (err_sum)
  );
`endif

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    in_d    = in_q;
    exp_d   = exp_q;
    learn_d = learn_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.s_valid) begin
          in_d    = bus.s_in;
          exp_d   = bus.s_expected;
          learn_d = bus.s_learn;
          idx_d   = cnt_q;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        wc_d    = WC_W'(INFER_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wc_q == '0) begin
          out_d = bus.layer_out;
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
          err_d = err_sum;
`endif
          if (learn_q) begin
            wc_d    = WC_W'(LEARN_CYCLES - 1);
            state_d = ST_LEARN;
          end else begin
            state_d = ST_RESULT;
          end
        end else begin
          wc_d = wc_q - 1'b1;
        end
      end
      ST_LEARN: begin
        if (wc_q == '0) state_d = ST_RESULT;
        else            wc_d    = wc_q - 1'b1;
      end
      ST_RESULT: begin
        // The sample index only advances once the result has been taken.
        if (bus.r_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wc_q    <= '0;
      in_q    <= '0;
      exp_q   <= '0;
      learn_q <= 1'b0;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      in_q    <= in_d;
      exp_q   <= exp_d;
      learn_q <= learn_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.s_ready            = (state_q == ST_IDLE);
  assign bus.busy               = (state_q != ST_IDLE);
  assign bus.layer_valid        = (state_q == ST_FIRE);
  assign bus.layer_learn        = (state_q == ST_LEARN);
  assign bus.layer_in           = in_q;
  assign bus.layer_expected_out = exp_q;
  assign bus.r_valid            = (state_q == ST_RESULT);
  assign bus.r_out              = out_q;
  assign bus.r_idx              = idx_q;
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
  assign bus.r_err              = err_q;
`endif

endmodule

// File: tb/tb_neuron_layer_train_seq.sv
// Bench for neuron_layer_train_seq: behavioural one-cycle-latency layer plus result scoreboard.
module tb_neuron_layer_train_seq;
  import neuron_layer_train_seq_pkg::*;

  localparam int N         = 16;
  localparam int M         = 56;
  localparam int INFER_LAT = 1;
  localparam int LC        = 3;
  localparam int CNT_W     = 2;
  localparam int ERR_W     = $bits(zero2one_t) + $clog2(M + 1);

  typedef zero2one_t [N-1:0] in_vec_t;
  typedef zero2one_t [M-1:0] out_vec_t;
  typedef struct {
    out_vec_t         out;
    logic [CNT_W-1:0] idx;
    logic [ERR_W-1:0] err;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sb_t              sb_q[$];
  logic [CNT_W-1:0] idx_model = '0;
  in_vec_t          last_in;
  out_vec_t         last_exp;
  logic             layer_zero = 1'b0;
  logic             prev_lv    = 1'b0;

  neuron_layer_train_seq_if #(.N(N), .M(M), .CNT_W(CNT_W)) bus ();

  neuron_layer_train_seq #(
    .N(N), .M(M), .INFER_LAT(INFER_LAT), .LEARN_CYCLES(LC), .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic out_vec_t model_out(input in_vec_t in);
    out_vec_t o;
    for (int j = 0; j < M; j++) o[j] = layer_zero ? 8'h00 : (in[j % N] ^ zero2one_t'(j * 7));
    return o;
  endfunction

  function automatic logic [ERR_W-1:0] err_of(input out_vec_t o, input out_vec_t e);
    int s = 0;
    for (int j = 0; j < M; j++) s += (o[j] > e[j]) ? int'(o[j] - e[j]) : int'(e[j] - o[j]);
    return ERR_W'(s);
  endfunction

  // Layer model: output is valid only in the single cycle after the layer_valid cycle, noise otherwise.
  always @(negedge clock) begin
    if (prev_lv === 1'b1) bus.layer_out = model_out(bus.layer_in);
    else for (int j = 0; j < M; j++) bus.layer_out[j] = zero2one_t'($urandom);
    prev_lv = bus.layer_valid;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    sb_q.delete();
    idx_model = '0;
  endtask

  task automatic send(input logic learn, input logic max_exp);
    sb_t e;
    int  n = 0;
    @(negedge clock);
    while (bus.s_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    for (int i = 0; i < N; i++) last_in[i] = zero2one_t'($urandom);
    for (int j = 0; j < M; j++) last_exp[j] = max_exp ? 8'hFF : zero2one_t'($urandom);
    bus.s_in = last_in; bus.s_expected = last_exp; bus.s_learn = learn; bus.s_valid = 1'b1;
    e.out = model_out(last_in); e.idx = idx_model; e.err = err_of(e.out, last_exp);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    bus.s_valid = 1'b0;
    for (int i = 0; i < N; i++) bus.s_in[i] = zero2one_t'($urandom);
    for (int j = 0; j < M; j++) bus.s_expected[j] = zero2one_t'($urandom);
    bus.s_learn = ~learn;
  endtask

  task automatic collect(input string tag);
    sb_t e;
    int  n = 0;
    while (bus.r_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    e = sb_q.pop_front();
    total++;
    if (n >= 50) begin
      bad++; $display("FAIL %s_timeout r_valid=%b required 1", tag, bus.r_valid);
    end else begin
      total++;
      if (bus.r_out !== e.out) begin bad++; $display("FAIL %s_r_out got=%h want=%h", tag, bus.r_out, e.out); end
      if (bus.r_idx !== e.idx) begin bad++; $display("FAIL %s_r_idx got=%0d want=%0d", tag, bus.r_idx, e.idx); end
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
      total++;
      if (bus.r_err !== e.err) begin bad++; $display("FAIL %s_r_err got=%0d want=%0d", tag, bus.r_err, e.err); end
`endif
    end
    bus.r_ready = 1'b1;
    @(posedge clock);
    #1 bus.r_ready = 1'b0;
    idx_model = idx_model + 1'b1;
    @(negedge clock);
    total++;
    if (bus.r_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      bad++; $display("FAIL %s_after_hs r_valid=%b s_ready=%b required 0/1", tag, bus.r_valid, bus.s_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b want=1", bus.s_ready); end
    total++; if (bus.r_valid !== 1'b0) begin bad++; $display("FAIL rst_r_valid got=%b want=0", bus.r_valid); end
    total++; if (bus.layer_valid !== 1'b0) begin bad++; $display("FAIL rst_layer_valid got=%b want=0", bus.layer_valid); end
    total++; if (bus.layer_learn !== 1'b0) begin bad++; $display("FAIL rst_layer_learn got=%b want=0", bus.layer_learn); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.r_idx !== '0) begin bad++; $display("FAIL rst_r_idx got=%0d want=0", bus.r_idx); end
    total++; if (bus.r_out !== '0) begin bad++; $display("FAIL rst_r_out got=%h want=0", bus.r_out); end
    total++; if (bus.layer_in !== '0 || bus.layer_expected_out !== '0) begin
      bad++; $display("FAIL rst_layer_regs in=%h exp=%h want 0", bus.layer_in, bus.layer_expected_out);
    end
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
    total++; if (bus.r_err !== '0) begin bad++; $display("FAIL rst_r_err got=%0d want=0", bus.r_err); end
`endif
  endtask

  task automatic test_inference();
    send(1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      total++; if (bus.layer_valid !== (k == 1)) begin bad++; $display("FAIL inf_layer_valid k=%0d got=%b want=%b", k, bus.layer_valid, k == 1); end
      total++; if (bus.layer_learn !== 1'b0) begin bad++; $display("FAIL inf_layer_learn k=%0d got=%b want=0", k, bus.layer_learn); end
      total++; if (bus.r_valid !== (k >= 2 + INFER_LAT)) begin bad++; $display("FAIL inf_r_valid k=%0d got=%b want=%b", k, bus.r_valid, k >= 2 + INFER_LAT); end
    end
    collect("inf");
  endtask

  task automatic test_training();
    send(1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      total++; if (bus.layer_valid !== (k == 1)) begin bad++; $display("FAIL trn_layer_valid k=%0d got=%b want=%b", k, bus.layer_valid, k == 1); end
      total++; if (bus.layer_learn !== (k >= 3 && k <= 2 + LC)) begin bad++; $display("FAIL trn_layer_learn k=%0d got=%b", k, bus.layer_learn); end
      total++; if (bus.r_valid !== (k >= 3 + LC)) begin bad++; $display("FAIL trn_r_valid k=%0d got=%b want=%b", k, bus.r_valid, k >= 3 + LC); end
      total++; if (bus.layer_in !== last_in || bus.layer_expected_out !== last_exp) begin
        bad++; $display("FAIL trn_layer_hold k=%0d in=%h want=%h", k, bus.layer_in, last_in);
      end
    end
    collect("trn");
  endtask

  task automatic test_backpressure();
    int n = 0;
    send(1'b0, 1'b0);
    while (bus.r_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      total++; if (bus.r_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
        bad++; $display("FAIL bp_handshake k=%0d r_valid=%b s_ready=%b required 1/0", k, bus.r_valid, bus.s_ready);
      end
      total++; if (bus.r_out !== sb_q[0].out || bus.r_idx !== sb_q[0].idx) begin
        bad++; $display("FAIL bp_hold k=%0d r_idx=%0d want=%0d", k, bus.r_idx, sb_q[0].idx);
      end
    end
    collect("bp");
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] want [5];
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int s = 0; s < 5; s++) begin
      send(s[0], 1'b0);
      repeat (3) @(negedge clock);
      total++; if (bus.r_idx !== want[s]) begin bad++; $display("FAIL wrap_idx s=%0d got=%0d want=%0d", s, bus.r_idx, want[s]); end
      collect("wrap");
    end
  endtask

`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
  task automatic test_err();
    int n = 0;
    layer_zero = 1'b1;
    send(1'b0, 1'b1);
    while (bus.r_valid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    total++; if (bus.r_err !== ERR_W'(M * 255)) begin bad++; $display("FAIL err_max got=%0d want=%0d", bus.r_err, M * 255); end
    collect("err");
    layer_zero = 1'b0;
  endtask
`endif

  task automatic test_reset_in_learn();
    int n = 0;
    send(1'b1, 1'b0);
    while (bus.layer_learn !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL rl_reach_learn layer_learn=%b required 1", bus.layer_learn); end
    reset = 1'b1;
    @(negedge clock);
    total++; if (bus.layer_learn !== 1'b0) begin bad++; $display("FAIL rl_layer_learn got=%b want=0", bus.layer_learn); end
    total++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin bad++; $display("FAIL rl_idle busy=%b s_ready=%b required 0/1", bus.busy, bus.s_ready); end
    total++; if (bus.r_valid !== 1'b0) begin bad++; $display("FAIL rl_r_valid got=%b want=0", bus.r_valid); end
    total++; if (bus.layer_in !== '0) begin bad++; $display("FAIL rl_layer_in got=%h want=0", bus.layer_in); end
    reset = 1'b0;
    sb_q.delete();
    idx_model = '0;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_learn = 1'b0; bus.r_ready = 1'b0;
    bus.s_in = '0; bus.s_expected = '0;
    test_reset();
    test_inference();
    test_training();
    test_backpressure();
    test_wrap();
`ifdef NEURON_LAYER_TRAIN_SEQ_ERR_EN
    test_err();
`endif
    test_reset_in_learn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
